// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS core: opcodes, functs, ALU codes and FSM states.
package mips_mc_pkg;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluSlt = 3'b111;

    typedef enum logic [3:0] {
        StIdle, StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
        StExec, StAluWb, StAddiEx, StAddiWb, StBranch, StJump, StHalt
    } state_e;

endpackage

// File: rtl/mc_reg_file.sv
// Register file: two asynchronous read ports, one synchronous write port, register 0 fixed at 0.
module mc_reg_file #(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [REG_ADDR_W-1:0] raddr_a,
    output logic [31:0]           rdata_a,
    input  logic [REG_ADDR_W-1:0] raddr_b,
    output logic [31:0]           rdata_b,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [31:0]           wdata
);
    localparam int NumRegs = 1 << REG_ADDR_W;

    logic [31:0] regs_q [NumRegs];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs_q[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs_q[raddr_b];

endmodule

// File: rtl/mips_multi_cycle_core.sv
// Multi-cycle MIPS-subset core: controller FSM, shared ALU and a req/ready unified memory port.
module mips_multi_cycle_core
    import mips_mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic        clk,
    input  logic        arst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic        halted
);
    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d;
    logic [31:0] a_q, a_d, b_q, b_d, alu_out_q, alu_out_d;

    logic [5:0]            opcode, funct;
    logic [REG_ADDR_W-1:0] rs, rt, rd;
    logic [31:0]           imm_sext;
    logic [31:0]           rf_rdata_a, rf_rdata_b, rf_wdata;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic                  rf_we;
    logic [31:0]           alu_a, alu_b, alu_y;
    logic [2:0]            alu_op, funct_alu;
    logic                  funct_ok;

    assign opcode   = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign rs       = ir_q[21 +: REG_ADDR_W];
    assign rt       = ir_q[16 +: REG_ADDR_W];
    assign rd       = ir_q[11 +: REG_ADDR_W];
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

    mc_reg_file #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_rf (
        .clk    (clk),
        .arst   (arst),
        .raddr_a(rs),
        .rdata_a(rf_rdata_a),
        .raddr_b(rt),
        .rdata_b(rf_rdata_b),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata)
    );

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = AluAdd;
        case (funct)
            FnAdd:   funct_alu = AluAdd;
            FnSub:   funct_alu = AluSub;
            FnAnd:   funct_alu = AluAnd;
            FnOr:    funct_alu = AluOr;
            FnSlt:   funct_alu = AluSlt;
            default: funct_ok  = 1'b0;
        endcase
    end

    // Operand select depends on state only, so the ALU never feeds back into its own inputs.
    always_comb begin
        alu_a  = a_q;
        alu_b  = imm_sext;
        alu_op = AluAdd;
        unique case (state_q)
            StFetch:  begin alu_a = pc_q; alu_b = 32'd4;         end
            StDecode: begin alu_a = pc_q; alu_b = imm_sext << 2; end
            StExec:   begin alu_b = b_q;  alu_op = funct_alu;    end
            default:  ;
        endcase
    end

    always_comb begin
        case (alu_op)
            AluAnd:  alu_y = alu_a & alu_b;
            AluOr:   alu_y = alu_a | alu_b;
            AluSub:  alu_y = alu_a - alu_b;
            AluSlt:  alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_y = alu_a + alu_b;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        mdr_d     = mdr_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        rf_we     = 1'b0;
        rf_waddr  = rt;
        rf_wdata  = alu_out_q;
        unique case (state_q)
            StIdle:   state_d = StFetch;
            StFetch: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = alu_y;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                a_d       = rf_rdata_a;
                b_d       = rf_rdata_b;
                alu_out_d = alu_y;
                case (opcode)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = funct_ok ? StExec : StHalt;
                    OpAddi:     state_d = StAddiEx;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
                    default:    state_d = StHalt;
                endcase
            end
            StMemAdr: begin
                alu_out_d = alu_y;
                state_d   = (opcode == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                if (mem_ready) begin
                    mdr_d   = mem_rdata;
                    state_d = StMemWb;
                end
            end
            StMemWb: begin
                rf_we    = 1'b1;
                rf_wdata = mdr_q;
                state_d  = StFetch;
            end
            StMemWr:  if (mem_ready) state_d = StFetch;
            StExec: begin
                alu_out_d = alu_y;
                state_d   = StAluWb;
            end
            StAluWb: begin
                rf_we    = 1'b1;
                rf_waddr = rd;
                state_d  = StFetch;
            end
            StAddiEx: begin
                alu_out_d = alu_y;
                state_d   = StAddiWb;
            end
            StAddiWb: begin
                rf_we   = 1'b1;
                state_d = StFetch;
            end
            StBranch: begin
                if (a_q == b_q) pc_d = alu_out_q;
                state_d = StFetch;
            end
            StJump: begin
                pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                state_d = StFetch;
            end
            StHalt:   state_d = StHalt;
            default:  state_d = StHalt;
        endcase
    end

    // Memory port is Moore: decoded from registered state so it holds steady across waits.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            StFetch: begin
                mem_req  = 1'b1;
                mem_addr = {pc_q[31:2], 2'b00};
            end
            StMemRd: begin
                mem_req  = 1'b1;
                mem_addr = {alu_out_q[31:2], 2'b00};
            end
            StMemWr: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {alu_out_q[31:2], 2'b00};
                mem_wdata = b_q;
            end
            default: ;
        endcase
    end

    assign pc     = pc_q;
    assign halted = (state_q == StHalt);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            mdr_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
        end
    end

endmodule

// File: tb/tb_mips_multi_cycle_core.sv
// Bench: memory responder with configurable wait states plus an instruction-level reference model.
module tb_mips_multi_cycle_core;
    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        mem_req, mem_we, mem_ready, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

    mips_multi_cycle_core #(
        .RESET_PC  (32'h0000_0000),
        .REG_ADDR_W(5)
    ) dut (
        .clk      (clk),
        .arst     (arst),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .pc       (pc),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    logic [31:0] mem [512];
    logic [31:0] img [512];
    logic [31:0] got_addr[$], got_data[$], exp_addr[$], exp_data[$];
    int          lat_mode, lat, wait_cnt, waits_total;
    bit          busy;
    logic        s_we;
    logic [31:0] s_addr, s_wdata;
    logic [5:0]  fn_list [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    function automatic int pick_lat(input logic [31:0] a);
        case (lat_mode)
            0:       return 0;
            2:       return 2;
            3:       return $urandom_range(0, 3);
            default: return (a == 32'h400) ? 1000000 : 0;
        endcase
    endfunction

    // Responder: decides ready at the negedge; the access completes on the following posedge.
    always @(negedge clk) begin
        if (arst || !mem_req) begin
            busy      = 1'b0;
            mem_ready = ($urandom_range(0, 1) == 1);
            mem_rdata = $urandom;
        end else begin
            if (!busy) begin
                busy     = 1'b1;
                wait_cnt = 0;
                lat      = pick_lat(mem_addr);
                s_we     = mem_we;
                s_addr   = mem_addr;
                s_wdata  = mem_wdata;
                check_eq("addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
            end else begin
                check_eq("stable_addr", mem_addr, s_addr);
                check_eq("stable_we", {31'd0, mem_we}, {31'd0, s_we});
                check_eq("stable_wdata", mem_wdata, s_wdata);
            end
            if (wait_cnt >= lat) begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr[10:2]];
                if (mem_we) begin
                    mem[mem_addr[10:2]] = mem_wdata;
                    got_addr.push_back(mem_addr);
                    got_data.push_back(mem_wdata);
                end
                waits_total += wait_cnt;
                busy = 1'b0;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                wait_cnt++;
            end
        end
    end

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] s,
                                          input logic [4:0] t, input logic [4:0] d);
        return {6'h00, s, t, d, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 'x;
    endfunction

    // ISA-level model: returns cycles (zero wait states) up to halt and the PC seen at halt.
    task automatic run_model(output int cyc, output logic [31:0] hpc);
        logic [31:0] rf [32];
        logic [31:0] mm [512];
        logic [31:0] p, ins, sx, va, vb, ea;
        logic [4:0]  rs, rt, rd;
        bit          legal;
        mm  = img;
        p   = 32'h0;
        cyc = 0;
        hpc = 32'hDEAD_BEEF;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        exp_addr.delete();
        exp_data.delete();
        for (int step = 0; step < 4000; step++) begin
            ins   = mm[p[10:2]];
            p     = p + 32'd4;
            rs    = ins[25:21];
            rt    = ins[20:16];
            rd    = ins[15:11];
            sx    = {{16{ins[15]}}, ins[15:0]};
            va    = rf[rs];
            vb    = rf[rt];
            legal = 1'b1;
            case (ins[31:26])
                6'h00: begin
                    cyc += 4;
                    case (ins[5:0])
                        6'h20:   rf[rd] = va + vb;
                        6'h22:   rf[rd] = va - vb;
                        6'h24:   rf[rd] = va & vb;
                        6'h25:   rf[rd] = va | vb;
                        6'h2A:   rf[rd] = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
                        default: begin legal = 1'b0; cyc -= 4; end
                    endcase
                end
                6'h08: begin cyc += 4; rf[rt] = va + sx; end
                6'h23: begin
                    cyc += 5;
                    ea = (va + sx) & 32'hFFFF_FFFC;
                    rf[rt] = mm[ea[10:2]];
                end
                6'h2B: begin
                    cyc += 4;
                    ea = (va + sx) & 32'hFFFF_FFFC;
                    mm[ea[10:2]] = vb;
                    exp_addr.push_back(ea);
                    exp_data.push_back(vb);
                end
                6'h04: begin cyc += 3; if (va == vb) p = p + (sx << 2); end
                6'h02: begin cyc += 3; p = {p[31:28], ins[25:0], 2'b00}; end
                default: legal = 1'b0;
            endcase
            rf[0] = '0;
            if (!legal) begin
                cyc += 2;
                hpc = p;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst = 1'b1;
        #1;
        check_eq("rst_req", {31'd0, mem_req}, 32'd0);
        check_eq("rst_we", {31'd0, mem_we}, 32'd0);
        check_eq("rst_addr", mem_addr, 32'd0);
        check_eq("rst_wdata", mem_wdata, 32'd0);
        check_eq("rst_halted", {31'd0, halted}, 32'd0);
        check_eq("rst_pc", pc, 32'd0);
        repeat (2) @(negedge clk);
        waits_total = 0;
        #1 arst = 1'b0;
        #1 check_eq("idle_noreq", {31'd0, mem_req}, 32'd0);
    endtask

    task automatic run_prog(input string name, input int mode, output int halt_n);
        int          exp_cyc;
        logic [31:0] exp_pc;
        lat_mode = mode;
        mem      = img;
        got_addr.delete();
        got_data.delete();
        run_model(exp_cyc, exp_pc);
        do_reset();
        halt_n = 0;
        do begin
            @(negedge clk);
            halt_n++;
            if (halt_n == 1) begin
                check_eq({name, ":first_req"}, {31'd0, mem_req}, 32'd1);
                check_eq({name, ":first_addr"}, mem_addr, 32'd0);
            end
        end while (!halted && halt_n < 5000);
        check_eq({name, ":halted"}, {31'd0, halted}, 32'd1);
        check_eq({name, ":nwrites"}, got_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size(); i++) begin
            check_eq({name, ":waddr"}, q_at(got_addr, i), exp_addr[i]);
            check_eq({name, ":wdata"}, q_at(got_data, i), exp_data[i]);
        end
        check_eq({name, ":halt_cycle"}, halt_n, 1 + exp_cyc + waits_total);
        check_eq({name, ":halt_pc"}, pc, exp_pc);
        repeat (6) begin
            @(negedge clk);
            check_eq({name, ":halt_noreq"}, {31'd0, mem_req}, 32'd0);
        end
    endtask

    task automatic build_random();
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        int          r;
        for (int i = 0; i < 512; i++) img[i] = $urandom;
        for (int i = 0; i < 56; i++) begin
            r   = $urandom_range(0, 99);
            rs  = 5'($urandom_range(0, 7));
            rt  = 5'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 7));
            imm = 16'($urandom);
            if (r < 28)      img[i] = enc_r(fn_list[$urandom_range(0, 4)], rs, rt, rd);
            else if (r < 48) img[i] = enc_i(6'h08, rs, rt, imm);
            else if (r < 70) begin
                imm = 16'(32'h400 + 4 * $urandom_range(0, 63) + $urandom_range(0, 3));
                img[i] = enc_i((r < 60) ? 6'h2B : 6'h23, 5'd0, rt, imm);
            end
            else if (r < 82) img[i] = enc_i(6'h04, rs, rt, 16'($urandom_range(0, 3)));
            else if (r < 88) img[i] = {6'h02, 26'(i + 1 + $urandom_range(0, 3))};
            else             img[i] = enc_i(6'h08, rs, rt, 16'($urandom_range(0, 15)));
        end
        for (int k = 0; k < 7; k++) img[56+k] = enc_i(6'h2B, 5'd0, 5'(k + 1), 16'(32'h480 + 4 * k));
        img[63] = 32'hFC00_0000;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 512; i++) img[i] = '0;
    endtask

    int n;

    initial begin
        // Arithmetic program, zero wait states, results stored out for observation.
        clear_img();
        img[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        img[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
        img[2] = enc_r(6'h20, 5'd1, 5'd2, 5'd3);
        img[3] = enc_r(6'h2A, 5'd2, 5'd1, 5'd4);
        img[4] = enc_r(6'h22, 5'd2, 5'd1, 5'd5);
        img[5] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0400);
        img[6] = enc_i(6'h2B, 5'd0, 5'd4, 16'h0404);
        img[7] = enc_i(6'h2B, 5'd0, 5'd5, 16'h0408);
        img[8] = 32'hFC00_0000;
        run_prog("arith", 0, n);
        check_eq("arith_r3", q_at(got_data, 0), 32'd2);
        check_eq("arith_r4", q_at(got_data, 1), 32'd1);
        check_eq("arith_r5", q_at(got_data, 2), 32'hFFFF_FFF8);
        check_eq("arith_cycles", n, 35);

        // sw then lw through two wait states per access.
        clear_img();
        img[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        img[1]  = {6'h02, 26'h10};
        img[16] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0008);
        img[17] = enc_i(6'h23, 5'd0, 5'd6, 16'h0008);
        img[18] = enc_i(6'h2B, 5'd0, 5'd6, 16'h0400);
        img[19] = 32'hFC00_0000;
        run_prog("memwait", 2, n);
        check_eq("memwait_sw_addr", q_at(got_addr, 0), 32'h8);
        check_eq("memwait_sw_data", q_at(got_data, 0), 32'd5);
        check_eq("memwait_r6", q_at(got_data, 1), 32'd5);

        // Branch taken, branch not taken, jump, write to $0.
        clear_img();
        img[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        for (int i = 1; i < 4; i++) img[i] = enc_i(6'h08, 5'd7, 5'd7, 16'd1);
        img[4]  = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
        img[5]  = enc_i(6'h08, 5'd0, 5'd2, 16'd99);
        img[6]  = enc_i(6'h08, 5'd0, 5'd2, 16'd99);
        img[7]  = enc_i(6'h04, 5'd1, 5'd0, 16'd3);
        img[8]  = {6'h02, 26'h40};
        img[64] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
        img[65] = enc_i(6'h2B, 5'd0, 5'd0, 16'h0400);
        img[66] = enc_i(6'h2B, 5'd0, 5'd2, 16'h0404);
        img[67] = enc_i(6'h2B, 5'd0, 5'd7, 16'h0408);
        img[68] = 32'hFC00_0000;
        run_prog("ctrl", 0, n);
        check_eq("ctrl_r0", q_at(got_data, 0), 32'd0);
        check_eq("ctrl_skip", q_at(got_data, 1), 32'd0);
        check_eq("ctrl_r7", q_at(got_data, 2), 32'd3);
        check_eq("ctrl_pc", pc, 32'h114);
        check_eq("ctrl_cycles", n, 44);

        // Unknown R-type funct halts right after decode.
        clear_img();
        img[0] = enc_r(6'h3F, 5'd1, 5'd2, 5'd3);
        run_prog("badfunct", 0, n);
        check_eq("badfunct_pc", pc, 32'h4);
        check_eq("badfunct_cycles", n, 3);

        // Randomized programs against the reference model.
        for (int t = 0; t < 4; t++) begin
            build_random();
            run_prog("random", (t == 0) ? 0 : 3, n);
        end

        // Reset during a stalled data read: MDR holds an earlier load before reset.
        clear_img();
        img[0]   = enc_i(6'h23, 5'd0, 5'd1, 16'h0500);
        img[1]   = enc_i(6'h23, 5'd0, 5'd2, 16'h0400);
        img[320] = 32'h1234_5678;
        lat_mode = 4;
        mem      = img;
        do_reset();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_req && mem_addr == 32'h400) && n < 100);
        check_eq("midrst_reached", mem_addr, 32'h400);
        repeat (2) @(negedge clk);
        #1 arst = 1'b1;
        #1;
        check_eq("midrst_req", {31'd0, mem_req}, 32'd0);
        check_eq("midrst_pc", pc, 32'd0);
        check_eq("midrst_mdr", dut.mdr_q, 32'd0);
        check_eq("midrst_halted", {31'd0, halted}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mips_multi_cycle_core.md
# mips_multi_cycle_core

Multi-cycle MIPS-subset processor core: a controller FSM plus a datapath with architectural registers IR, MDR, A, B and ALUOut, sharing one ALU and one unified instruction/data memory port. The memory port has a req/ready handshake, so it tolerates any number of wait states. It replaces the single-cycle datapath-plus-decoder pair as the next-generation processor block. It sits between the top level and a single-port memory.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `REG_ADDR_W`, 5, register-file address width; the register count is 2**REG_ADDR_W. Unused instruction address bits above REG_ADDR_W are ignored.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `arst`  in  1  asynchronous reset, active-high.
- `mem_req`  out  1  memory transaction request.
- `mem_we`  out  1  1 = write, 0 = read; valid only while `mem_req` = 1.
- `mem_addr`  out  32  byte address, word aligned.
- `mem_wdata`  out  32  store data.
- `mem_rdata`  in  32  read data; valid in the cycle `mem_ready` = 1.
- `mem_ready`  in  1  transaction completes in a cycle where `mem_req` = `mem_ready` = 1.
- `pc`  out  32  current PC register.
- `halted`  out  1  core stopped on an illegal instruction.

## Operation
- Supported instructions, with opcode/funct in hex:
  - R-type, opcode 00: add 20, sub 22, and 24, or 25, slt 2A.
  - lw 23, sw 2B, beq 04, addi 08, j 02.
- ALU codes: AND 000, OR 001, ADD 010, SUB 110, SLT 111 (signed compare, result 0 or 1).
- FSM states and transitions:
  - IDLE → FETCH.
  - FETCH: read at PC. On completion, IR ← rdata and PC ← PC+4; go to DECODE. Otherwise hold.
  - DECODE: A ← rf[rs], B ← rf[rt], ALUOut ← PC + (signext(imm) << 2). Then by opcode: MEMADR (lw/sw), EXEC (R), ADDI_EX, BRANCH, JUMP. Any other opcode, or an unknown R funct, goes to HALT.
  - MEMADR: ALUOut ← A + signext(imm); go to MEMRD (lw) or MEMWR (sw).
  - MEMRD: read at ALUOut; on completion MDR ← rdata, go to MEM_WB.
  - MEM_WB: rf[rt] ← MDR; go to FETCH.
  - MEMWR: write B at ALUOut; on completion go to FETCH.
  - EXEC: ALUOut ← A op B; go to ALU_WB.
  - ALU_WB: rf[rd] ← ALUOut; go to FETCH.
  - ADDI_EX: ALUOut ← A + signext(imm); go to ADDI_WB.
  - ADDI_WB: rf[rt] ← ALUOut; go to FETCH.
  - BRANCH: if A == B then PC ← ALUOut; go to FETCH.
  - JUMP: PC ← {PC[31:28], instr[25:0], 2'b00}; go to FETCH.
  - HALT: absorbing. `halted` = 1, `mem_req` = 0. Left only by reset.
- Register file: two asynchronous read ports and one synchronous write port. Writes to register 0 are discarded; register 0 always reads 0.
- All arithmetic is 32-bit modulo 2^32; overflow is ignored. PC+4 wraps from FFFF_FFFC to 0000_0000.
- `mem_addr` bits [1:0] are always 00. The low two bits of the computed lw/sw address are forced to 0; there is no misalignment trap.

## Timing
- Reset values while `arst` = 1:
  - state IDLE, `pc` = RESET_PC.
  - IR, MDR, A, B, ALUOut and all registers = 0.
  - `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `halted` = 0.
- Memory outputs are Moore, decoded from the state register only.
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` stay stable for the whole request.
  - `mem_ready` may be high in the first request cycle, i.e. zero wait states.
  - `mem_ready` is ignored when `mem_req` = 0.
- Cycles per instruction with zero wait states: beq 3, j 3, R-type 4, addi 4, sw 4, lw 5. Each memory wait state adds one cycle.
- The first fetch request appears in the cycle after reset deasserts (the IDLE cycle).
- Reset asserted mid-transaction: `mem_req` drops asynchronously and the pending access is abandoned. No state or register update results from it.
- A register written in a *_WB state is visible to the DECODE of the next instruction.

## Structure
- Package `mips_mc_pkg`: opcode, funct and ALU-code localparams, plus the state enum encoding (4 bits).
- Sub-module `mc_reg_file`, parameterised by REG_ADDR_W. The ALU, controller FSM and datapath registers stay in the core.

## Test plan
- Reset check: hold `arst`, then release it. All outputs take their reset values. The first `mem_req` occurs one cycle after release with `mem_addr` = RESET_PC.
- Arithmetic program, zero wait states:
  - addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1; sub $5,$2,$1.
  - Expected: $3 = 2, $4 = 1, $5 = FFFF_FFF8, in 20 cycles total.
- Memory with wait states: sw $1,8($0) then lw $6,8($0), with 2-cycle `mem_ready` latency.
  - Write seen at addr 8 with data 5; $6 = 5.
  - Request signals stable across the waits; sw takes 6 cycles and lw takes 9.
- Control flow:
  - beq $1,$1,+2 at PC 0x10 → PC = 0x1C.
  - beq not taken → PC = 0x14.
  - j 0x40 → PC = 0x100.
  - addi $0,$0,7 followed by reading $0 → reads 0.
- Illegal opcode 3F → enters HALT after DECODE: `halted` = 1, no further `mem_req`. Reset clears the halt.
- Reset mid-MEMRD with `mem_ready` low → `mem_req` drops in the same cycle, MDR = 0, PC = RESET_PC.
